// File: rtl/tile_accum.sv
// Result collector behind the multiply/reduce tile: FP16 dot-product accumulation or vector
// pass-through into one valid/ready output register. Define TILE_ACCUM_FLAG_EN for out_flag_o.
module tile_accum #(
    parameter int unsigned TILE_SIZE = 128,
    parameter int unsigned MUL_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic                           in_mode_i,
    input  logic                           in_last_i,
    input  logic [MUL_WIDTH-1:0]           in_scal_i,
    input  logic [TILE_SIZE*MUL_WIDTH-1:0] in_vec_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic                           out_mode_o,
    output logic [MUL_WIDTH-1:0]           out_scal_o,
    output logic [TILE_SIZE*MUL_WIDTH-1:0] out_vec_o,
    output logic [CNT_WIDTH-1:0]           out_count_o
`ifdef TILE_ACCUM_FLAG_EN
    ,
    output logic                           out_flag_o
`endif
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StAcc} state_t;

    // IEEE binary16 add, round-to-nearest-even, canonical quiet NaN 7E00.
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic        a_nan, b_nan, a_inf, b_inf;
        logic [15:0] x, y, res;
        logic [4:0]  ex, ey, d;
        logic [13:0] mx, my, my_sh, m;
        logic        sticky, up;
        logic [14:0] s;
        logic [6:0]  e;
        logic [11:0] r;
        a_nan  = (&a[14:10]) && (|a[9:0]);
        b_nan  = (&b[14:10]) && (|b[9:0]);
        a_inf  = (&a[14:10]) && !(|a[9:0]);
        b_inf  = (&b[14:10]) && !(|b[9:0]);
        x      = a;
        y      = b;
        res    = 16'h0000;
        my_sh  = '0;
        sticky = 1'b0;
        s      = '0;
        m      = '0;
        e      = '0;
        r      = '0;
        up     = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
            res = 16'h7E00;
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = b;
        end else begin
            if (a[14:0] < b[14:0]) begin
                x = b;
                y = a;
            end
            ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
            ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
            mx = {(x[14:10] != 5'd0), x[9:0], 3'b000};
            my = {(y[14:10] != 5'd0), y[9:0], 3'b000};
            d  = ex - ey;
            if (d >= 5'd14) begin
                my_sh  = '0;
                sticky = |my;
            end else begin
                my_sh  = my >> d;
                sticky = |(my & ((14'd1 << d) - 14'd1));
            end
            my_sh[0] = my_sh[0] | sticky;
            e = {2'b00, ex};
            if (x[15] == y[15]) begin
                s = {1'b0, mx} + {1'b0, my_sh};
                if (s[14]) begin
                    m = s[14:1] | {13'd0, s[0]};
                    e = e + 7'd1;
                end else begin
                    m = s[13:0];
                end
            end else begin
                s = {1'b0, mx} - {1'b0, my_sh};
                m = s[13:0];
                // Massive cancellation only occurs when alignment lost no bits.
                for (int i = 0; i < 13; i++) begin
                    if (!m[13] && (e > 7'd1)) begin
                        m = m << 1;
                        e = e - 7'd1;
                    end
                end
            end
            up = m[2] && (m[1] || m[0] || m[3]);
            r  = {1'b0, m[13:3]} + {11'd0, up};
            if (r[11]) begin
                r = r >> 1;
                e = e + 7'd1;
            end
            if (m == 14'd0) begin
                res = (x[15] == y[15]) ? {x[15], 15'd0} : 16'h0000;
            end else if (e >= 7'd31) begin
                res = {x[15], 5'h1F, 10'd0};
            end else if (!r[10]) begin
                res = {x[15], 5'd0, r[9:0]};
            end else begin
                res = {x[15], e[4:0], r[9:0]};
            end
        end
        return res;
    endfunction

    state_t                   r_state;
    state_t                   w_state_next;
    logic [MUL_WIDTH-1:0]     r_acc;
    logic [CNT_WIDTH-1:0]     r_cnt;
    logic [MUL_WIDTH-1:0]     w_sum;
    logic [MUL_WIDTH-1:0]     w_acc_new;
    logic [CNT_WIDTH-1:0]     w_cnt_new;
    logic                     w_in_fire;
    logic                     w_scal_fire;
    logic                     w_vec_fire;
    logic                     w_term;

    logic                           r_out_valid;
    logic                           r_out_mode;
    logic [MUL_WIDTH-1:0]           r_out_scal;
    logic [TILE_SIZE*MUL_WIDTH-1:0] r_out_vec;
    logic [CNT_WIDTH-1:0]           r_out_count;

    assign in_ready_o  = !r_out_valid || out_ready_i;
    assign w_in_fire   = in_valid_i && in_ready_o;
    assign w_scal_fire = w_in_fire && in_mode_i;
    assign w_vec_fire  = w_in_fire && !in_mode_i;
    assign w_term      = w_scal_fire && in_last_i;
    assign w_sum       = fp16_add(r_acc, in_scal_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_scal_fire && !in_last_i) w_state_next = StAcc;
            StAcc:  if (w_term) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // First chunk is loaded as-is so a lone -0 keeps its sign.
    always_comb begin
        w_acc_new = in_scal_i;
        w_cnt_new = CntOne;
        if (r_state == StAcc) begin
            w_acc_new = w_sum;
            w_cnt_new = (r_cnt == CntMax) ? r_cnt : r_cnt + CntOne;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_scal_fire) begin
            r_acc <= w_acc_new;
            r_cnt <= w_cnt_new;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_mode  <= 1'b0;
            r_out_scal  <= '0;
            r_out_vec   <= '0;
            r_out_count <= '0;
        end else if (w_term) begin
            r_out_valid <= 1'b1;
            r_out_mode  <= 1'b1;
            r_out_scal  <= w_acc_new;
            r_out_count <= w_cnt_new;
        end else if (w_vec_fire) begin
            r_out_valid <= 1'b1;
            r_out_mode  <= 1'b0;
            r_out_vec   <= in_vec_i;
            r_out_count <= CntOne;
        end else if (r_out_valid && out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_mode_o  = r_out_mode;
    assign out_scal_o  = r_out_scal;
    assign out_vec_o   = r_out_vec;
    assign out_count_o = r_out_count;

`ifdef TILE_ACCUM_FLAG_EN
    logic r_flag;
    logic r_out_flag;
    logic w_flag_new;

    // Sticky Inf/NaN seen in any loaded or summed value of the open dot product.
    assign w_flag_new = ((r_state == StAcc) && r_flag) || (&w_acc_new[14:10]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_flag <= 1'b0;
        end else if (w_scal_fire) begin
            r_flag <= in_last_i ? 1'b0 : w_flag_new;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_flag <= 1'b0;
        end else if (w_term) begin
            r_out_flag <= w_flag_new;
        end else if (w_vec_fire) begin
            r_out_flag <= 1'b0;
        end
    end

    assign out_flag_o = r_out_flag;
`endif

endmodule
